// File: rtl/vga_display_controller.sv
// VGA raster timing generator: pixel-enable divider, h/v counters, registered sync/active decode
// and one-clk line/frame ticks for per-frame game logic.
module vga_display_controller #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_ACT_START = 144,
    parameter int unsigned H_ACT_END   = 784,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_ACT_START = 35,
    parameter int unsigned V_ACT_END   = 515
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       line_tick,
    output logic       frame_tick
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

    localparam logic [9:0] HMax      = 10'(H_TOTAL - 1);
    localparam logic [9:0] VMax      = 10'(V_TOTAL - 1);
    localparam logic [9:0] HSyncEnd  = 10'(H_SYNC);
    localparam logic [9:0] VSyncEnd  = 10'(V_SYNC);
    localparam logic [9:0] HActStart = 10'(H_ACT_START);
    localparam logic [9:0] HActEnd   = 10'(H_ACT_END);
    localparam logic [9:0] VActStart = 10'(V_ACT_START);
    localparam logic [9:0] VActEnd   = 10'(V_ACT_END);

    logic [DivW-1:0] div_q, div_d;
    logic            pix_en_q, pix_en_d;
    logic [9:0]      h_q, h_d;
    logic [9:0]      v_q, v_d;
    logic            hsync_q, hsync_d;
    logic            vsync_q, vsync_d;
    logic            bright_q, bright_d;

    always_comb begin
        div_d    = (div_q == DivMax) ? '0 : div_q + 1'b1;
        pix_en_d = (div_d == DivMax);
        h_d      = h_q;
        v_d      = v_q;
        if (pix_en_q) begin
            if (h_q == HMax) begin
                h_d = '0;
                v_d = (v_q == VMax) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
        // Decode from next-state counters so registered outputs line up with hCount/vCount.
        hsync_d  = (h_d >= HSyncEnd);
        vsync_d  = (v_d >= VSyncEnd);
        bright_d = (h_d >= HActStart) && (h_d < HActEnd) && (v_d >= VActStart) && (v_d < VActEnd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= '0;
            pix_en_q <= 1'b0;
            h_q      <= '0;
            v_q      <= '0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            bright_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            pix_en_q <= pix_en_d;
            h_q      <= h_d;
            v_q      <= v_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            bright_q <= bright_d;
        end
    end

    assign pix_en     = pix_en_q;
    assign hCount     = h_q;
    assign vCount     = v_q;
    assign hSync      = hsync_q;
    assign vSync      = vsync_q;
    assign bright     = bright_q;
    assign line_tick  = pix_en_q && (h_q == HMax);
    assign frame_tick = line_tick && (v_q == VMax);

endmodule

// File: tb/tb_vga_display_controller.sv
// Directed bench: default 640x480 timing plus scaled-down instances for frame-level behaviour.
module tb_vga_display_controller;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    // Default-parameter instance
    logic       d_pe, d_hs, d_vs, d_br, d_lt, d_ft;
    logic [9:0] d_h, d_v;
    // Small instance: CLK_DIV 2, 12x8 raster, line 24 clk, frame 192 clk
    logic       s_pe, s_hs, s_vs, s_br, s_lt, s_ft;
    logic [9:0] s_h, s_v;
    // CLK_DIV 1 instance: 20x10 raster, frame 200 clk
    logic       o_pe, o_hs, o_vs, o_br, o_lt, o_ft;
    logic [9:0] o_h, o_v;

    vga_display_controller u_def (
        .clk(clk), .rst(rst), .pix_en(d_pe), .hCount(d_h), .vCount(d_v), .hSync(d_hs),
        .vSync(d_vs), .bright(d_br), .line_tick(d_lt), .frame_tick(d_ft)
    );

    vga_display_controller #(
        .CLK_DIV(2), .H_TOTAL(12), .H_SYNC(2), .H_ACT_START(3), .H_ACT_END(10),
        .V_TOTAL(8), .V_SYNC(1), .V_ACT_START(2), .V_ACT_END(7)
    ) u_small (
        .clk(clk), .rst(rst), .pix_en(s_pe), .hCount(s_h), .vCount(s_v), .hSync(s_hs),
        .vSync(s_vs), .bright(s_br), .line_tick(s_lt), .frame_tick(s_ft)
    );

    vga_display_controller #(
        .CLK_DIV(1), .H_TOTAL(20), .H_SYNC(3), .H_ACT_START(5), .H_ACT_END(17),
        .V_TOTAL(10), .V_SYNC(2), .V_ACT_START(3), .V_ACT_END(8)
    ) u_one (
        .clk(clk), .rst(rst), .pix_en(o_pe), .hCount(o_h), .vCount(o_v), .hSync(o_hs),
        .vSync(o_vs), .bright(o_br), .line_tick(o_lt), .frame_tick(o_ft)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sampling and driving both happen at negedge; return leaves us in "cycle 1" after reset.
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({d_pe, d_lt, d_ft, d_hs, d_vs, d_br, d_h, d_v} !== 26'd0) begin
            errors++;
            $display("FAIL reset_default got %b want all zero",
                     {d_pe, d_lt, d_ft, d_hs, d_vs, d_br, d_h, d_v});
        end
        checks++;
        if ({s_pe, s_lt, s_ft, s_hs, s_vs, s_br, s_h, s_v} !== 26'd0) begin
            errors++;
            $display("FAIL reset_small got %b want all zero",
                     {s_pe, s_lt, s_ft, s_hs, s_vs, s_br, s_h, s_v});
        end
    endtask

    task automatic test_pix_en();
        logic       exp_pe;
        logic [9:0] exp_h;
        do_reset();
        for (int c = 1; c <= 8; c++) begin
            exp_pe = (c == 4) || (c == 8);
            exp_h  = (c <= 4) ? 10'd0 : 10'd1;
            checks++;
            if ({d_pe, d_h, d_hs, d_vs, d_br} !== {exp_pe, exp_h, 3'b000}) begin
                errors++;
                $display("FAIL pix_en_cycle%0d got pe=%b h=%0d hs=%b vs=%b br=%b want pe=%b h=%0d 0 0 0",
                         c, d_pe, d_h, d_hs, d_vs, d_br, exp_pe, exp_h);
            end
            if (c != 8) @(negedge clk);
        end
    endtask

    task automatic test_line();
        int pos_bad, lt_cnt, lt_first, lt_bad, hs_low, vs_low, br_cnt;
        pos_bad = 0; lt_cnt = 0; lt_first = 0; lt_bad = 0; hs_low = 0; vs_low = 0; br_cnt = 0;
        do_reset();
        for (int c = 1; c <= 6400; c++) begin
            if (d_h !== 10'(((c - 1) / 4) % 800) || d_v !== 10'((c - 1) / 3200)) pos_bad++;
            if (d_lt) begin
                lt_cnt++;
                if (lt_first == 0) lt_first = c;
                if (!(d_pe && d_h == 10'd799)) lt_bad++;
            end
            if (c <= 3200 && !d_hs) hs_low++;
            if (!d_vs) vs_low++;
            if (d_br) br_cnt++;
            @(negedge clk);
        end
        checks++;
        if (pos_bad != 0) begin
            errors++; $display("FAIL line_counters got %0d bad cycles want 0", pos_bad);
        end
        checks++;
        if (lt_cnt != 2) begin
            errors++; $display("FAIL line_tick_count got %0d want 2", lt_cnt);
        end
        checks++;
        if (lt_first != 3200) begin
            errors++; $display("FAIL line_tick_cycle got %0d want 3200", lt_first);
        end
        checks++;
        if (lt_bad != 0) begin
            errors++; $display("FAIL line_tick_position got %0d bad want 0", lt_bad);
        end
        checks++;
        if (hs_low != 384) begin
            errors++; $display("FAIL hsync_low got %0d want 384", hs_low);
        end
        checks++;
        if (vs_low != 6400) begin
            errors++; $display("FAIL vsync_low got %0d want 6400", vs_low);
        end
        checks++;
        if (br_cnt != 0) begin
            errors++; $display("FAIL bright_in_blank got %0d want 0", br_cnt);
        end
        checks++;
        if ({d_h, d_v, d_vs} !== {10'd0, 10'd2, 1'b1}) begin
            errors++; $display("FAIL line_wrap got h=%0d v=%0d vs=%b want h=0 v=2 vs=1", d_h, d_v, d_vs);
        end
    endtask

    task automatic test_frame();
        int hm, vm, pos_bad, ft_cnt, ft_first, ft_second, ft_bad, lt_cnt, hs_low, vs_low, br_cnt;
        int br_first;
        logic b_start, b_end, b_left, b_right, b_top, b_bot;
        pos_bad = 0; ft_cnt = 0; ft_first = 0; ft_second = 0; ft_bad = 0; lt_cnt = 0;
        hs_low = 0; vs_low = 0; br_cnt = 0; br_first = 0;
        b_start = 1'b0; b_end = 1'b0; b_left = 1'b1; b_right = 1'b1; b_top = 1'b1; b_bot = 1'b1;
        do_reset();
        for (int c = 1; c <= 384; c++) begin
            hm = ((c - 1) / 2) % 12;
            vm = ((c - 1) / 24) % 8;
            if (s_h !== 10'(hm) || s_v !== 10'(vm)) pos_bad++;
            if (s_ft) begin
                ft_cnt++;
                if (ft_first == 0) ft_first = c; else ft_second = c;
                if (!(s_h == 10'd11 && s_v == 10'd7 && s_lt)) ft_bad++;
            end
            if (c <= 192) begin
                if (s_lt) lt_cnt++;
                if (!s_hs) hs_low++;
                if (!s_vs) vs_low++;
                if (s_br) begin
                    br_cnt++;
                    if (br_first == 0) br_first = c;
                end
                if (((c - 1) % 2) == 1) begin
                    if (hm == 3 && vm == 2) b_start = s_br;
                    if (hm == 9 && vm == 6) b_end = s_br;
                    if (hm == 2 && vm == 2) b_left = s_br;
                    if (hm == 10 && vm == 2) b_right = s_br;
                    if (hm == 3 && vm == 1) b_top = s_br;
                    if (hm == 3 && vm == 7) b_bot = s_br;
                end
            end
            @(negedge clk);
        end
        checks++;
        if (pos_bad != 0) begin
            errors++; $display("FAIL frame_counters got %0d bad cycles want 0", pos_bad);
        end
        checks++;
        if (ft_cnt != 2 || ft_first != 192 || ft_second != 384) begin
            errors++;
            $display("FAIL frame_tick got count=%0d at %0d,%0d want count=2 at 192,384",
                     ft_cnt, ft_first, ft_second);
        end
        checks++;
        if (ft_bad != 0) begin
            errors++; $display("FAIL frame_tick_position got %0d bad want 0", ft_bad);
        end
        checks++;
        if (lt_cnt != 8) begin
            errors++; $display("FAIL frame_line_ticks got %0d want 8", lt_cnt);
        end
        checks++;
        if (hs_low != 32 || vs_low != 24) begin
            errors++; $display("FAIL frame_sync_low got hs=%0d vs=%0d want hs=32 vs=24", hs_low, vs_low);
        end
        checks++;
        if (br_cnt != 70) begin
            errors++; $display("FAIL bright_total got %0d want 70", br_cnt);
        end
        checks++;
        if (br_first != 55) begin
            errors++; $display("FAIL bright_first_cycle got %0d want 55", br_first);
        end
        checks++;
        if ({b_start, b_end, b_left, b_right, b_top, b_bot} !== 6'b110000) begin
            errors++;
            $display("FAIL bright_corners got %b want 110000",
                     {b_start, b_end, b_left, b_right, b_top, b_bot});
        end
        checks++;
        if ({s_h, s_v} !== 20'd0) begin
            errors++; $display("FAIL frame_wrap got h=%0d v=%0d want 0 0", s_h, s_v);
        end
    endtask

    task automatic test_mid_reset();
        logic s_exp_pe;
        do_reset();
        for (int c = 1; c < 2003; c++) @(negedge clk);
        checks++;
        if (d_h !== 10'd500) begin
            errors++; $display("FAIL mid_reset_setup got h=%0d want 500", d_h);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({d_pe, d_lt, d_ft, d_hs, d_vs, d_br, d_h, d_v,
             s_pe, s_lt, s_ft, s_hs, s_vs, s_br, s_h, s_v} !== 52'd0) begin
            errors++;
            $display("FAIL mid_reset_clear got d=%b s=%b want all zero",
                     {d_pe, d_lt, d_ft, d_hs, d_vs, d_br, d_h, d_v},
                     {s_pe, s_lt, s_ft, s_hs, s_vs, s_br, s_h, s_v});
        end
        for (int c = 1; c <= 6; c++) begin
            s_exp_pe = (c % 2) == 0;
            checks++;
            if ({d_pe, s_pe, d_lt, d_ft, s_lt, s_ft} !== {(c == 4), s_exp_pe, 4'b0000}) begin
                errors++;
                $display("FAIL mid_reset_restart_cycle%0d got dpe=%b spe=%b ticks=%b want dpe=%b spe=%b ticks=0000",
                         c, d_pe, s_pe, {d_lt, d_ft, s_lt, s_ft}, (c == 4), s_exp_pe);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_div1();
        int pe_bad, pos_bad, ft_cnt, ft_first, ft_second, k;
        pe_bad = 0; pos_bad = 0; ft_cnt = 0; ft_first = 0; ft_second = 0;
        do_reset();
        checks++;
        if (o_pe !== 1'b0) begin
            errors++; $display("FAIL div1_reset_pe got %b want 0", o_pe);
        end
        for (int c = 1; c <= 401; c++) begin
            k = (c < 2) ? 0 : c - 2;
            if (c >= 2 && o_pe !== 1'b1) pe_bad++;
            if (o_h !== 10'(k % 20) || o_v !== 10'((k / 20) % 10)) pos_bad++;
            if (o_ft) begin
                ft_cnt++;
                if (ft_first == 0) ft_first = c; else ft_second = c;
            end
            @(negedge clk);
        end
        checks++;
        if (pe_bad != 0) begin
            errors++; $display("FAIL div1_pix_en got %0d low cycles want 0", pe_bad);
        end
        checks++;
        if (pos_bad != 0) begin
            errors++; $display("FAIL div1_counters got %0d bad cycles want 0", pos_bad);
        end
        checks++;
        if (ft_cnt != 2 || (ft_second - ft_first) != 200) begin
            errors++;
            $display("FAIL div1_frame_period got count=%0d at %0d,%0d want count=2 period 200",
                     ft_cnt, ft_first, ft_second);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        test_reset();
        test_pix_en();
        test_line();
        test_frame();
        test_mid_reset();
        test_div1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
